bus_ram: RTL and testbench
==========================

# bus_ram

Word-organised single-port RAM slave on the CPU's PicoRV32-native memory bus. It sits directly downstream of `cpu` and services both instruction fetches and LW/SW data accesses. Each accepted request is answered with a one-cycle `mem_ready` pulse after a parameterised number of wait states. Byte-lane writes follow `mem_wstrb`, and out-of-range accesses complete with an error flag so the bus never hangs.

## Interface
- `DEPTH_WORDS`, default 4096: RAM size in 32-bit words; power of two, ≥ 16.
- `WAIT_CYCLES`, default 1: extra wait states per access; range 0..15.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- `ROM_BYTES`, default 1024: size of the write-protected region starting at BASE_ADDR. Used only with the configuration macro.
- `clk` in 1: clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `mem_valid` in 1: request valid from the CPU.
- `mem_instr` in 1: request is an instruction fetch; informational only.
- `mem_addr` in 32: byte address; bits [1:0] are ignored.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte write enables; 4'b0000 means a read.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_rdata` out 32: read data; valid only while `mem_ready`=1.
- `bus_err` out 1: pulses together with `mem_ready` when the access was rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with `mem_valid`=1, latch addr, wdata, wstrb.
  - Load wait counter = WAIT_CYCLES.
  - Go to WAIT.
- WAIT:
  - If counter ≠ 0: decrement the counter.
  - Otherwise: perform the array access, register the result, and go to RESP.
- RESP:
  - `mem_ready`=1 for exactly this one cycle.
  - Go to IDLE unconditionally.
  - `mem_valid` is not sampled in RESP; a request still asserted is re-accepted in IDLE on the next edge.
- Offset and index:
  - offset = latched addr − BASE_ADDR, as a 32-bit unsigned wrap-around subtraction.
  - Word index = offset[31:2].
- In range means offset < DEPTH_WORDS·4. An out-of-range access:
  - performs no array write;
  - returns `mem_rdata`=32'h0;
  - drives `bus_err`=1 during RESP.
- Read (wstrb=0): `mem_rdata` = array[index].
- Write: for each i with wstrb[i]=1, byte lane i of array[index] ← wdata[8i+7:8i]. Other lanes are unchanged; `mem_rdata`=32'h0.
- `mem_valid` dropped mid-transaction is a protocol violation. The transaction still completes with a `mem_ready` pulse.

## Timing
- E0 is the first edge on which IDLE sees `mem_valid`=1. `mem_ready` is high in the cycle after edge E0+WAIT_CYCLES+1.
  - WAIT_CYCLES=0: ready 2 cycles after the request.
  - Default WAIT_CYCLES=1: ready 3 cycles after the request.
- Throughput: one transaction per WAIT_CYCLES+3 cycles, counting the mandatory IDLE cycle.
- `mem_ready`, `mem_rdata` and `bus_err` are registered outputs with no combinational path from the inputs.
- Reset values: state IDLE, `mem_ready`=0, `mem_rdata`=32'h0, `bus_err`=0, counter 0.
- Reset asserted mid-transaction:
  - The access is abandoned and no `mem_ready` pulse is issued.
  - An array write already performed on that edge stands.
  - Array contents are never cleared by reset.

## Configuration
- `BUS_RAM_ROM_GUARD_EN` defined:
  - Any write with offset < ROM_BYTES is rejected: no array change, `bus_err`=1 in RESP.
  - Reads in that region behave normally.
- Undefined: the whole array is writable, and ROM_BYTES is unused.

## Structure
- Package `bus_ram_pkg`: state enum `bus_ram_state_t` (IDLE, WAIT, RESP) and the width constant for the wait counter (4 bits).
- Sub-module `bus_ram_array`:
  - Single-port, synchronous-read/write array with 4 byte-lane write enables.
  - Behaviour: read returns the pre-write word.
  - The FSM, counter, address checks and guard logic stay in `bus_ram`.

## Test plan
- Reset, then idle for 10 cycles → `mem_ready`=0, `mem_rdata`=0, `bus_err`=0 throughout.
- WAIT_CYCLES=1: write 32'hDEADBEEF, wstrb 4'b1111 to 0x100, then read 0x100 → each `mem_ready` pulse exactly 1 cycle, 3 cycles after `mem_valid`; read returns 32'hDEADBEEF.
- Byte lanes:
  - Stimulus: after the above, write 32'h000000AA with wstrb 4'b0001 to 0x100, then read 0x100.
  - Required: read returns 32'hDEADBEAA.
- Out-of-range, DEPTH_WORDS=16: write, then read 0x40 → both complete with `bus_err`=1; read returns 32'h0; words 0..15 unchanged.
- Reset asserted in WAIT during a write to 0x20 with WAIT_CYCLES=3 → no `mem_ready` pulse; a later read of 0x20 returns the prior contents.
- `BUS_RAM_ROM_GUARD_EN` with ROM_BYTES=1024:
  - Write to 0x3FC: `bus_err`=1 and data unchanged.
  - Write to 0x400: succeeds.
  - Read of 0x3FC: `bus_err`=0.

Source files
------------

// File: rtl/bus_ram_pkg.sv
// rtl/bus_ram_pkg.sv - shared types and constants for the bus_ram slave
package bus_ram_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_ram_state_t;

endpackage

// File: rtl/bus_ram_array.sv
// rtl/bus_ram_array.sv - single-port word array with byte-lane write enables
// Synchronous read returns the word as it was before a same-cycle write.
module bus_ram_array
  import bus_ram_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/bus_ram.sv
// rtl/bus_ram.sv - PicoRV32-native bus RAM slave with wait states and error completion
// Optional write protection of the low ROM_BYTES region: BUS_RAM_ROM_GUARD_EN.
module bus_ram
  import bus_ram_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ROM_BYTES   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        bus_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_L   = 32'(DEPTH_WORDS);
  localparam logic [31:0] ROM_LIMIT = 32'(ROM_BYTES);
`ifdef BUS_RAM_ROM_GUARD_EN
  localparam bit          ROM_GUARD = 1'b1;
`else
  localparam bit          ROM_GUARD = 1'b0;
`endif

  bus_ram_state_t        state, next_state;
  logic [WAIT_CNT_W-1:0] cnt;
  logic [31:0]           addr_q, wdata_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           offset;
  logic                  in_range, rom_hit, reject, access;
  logic                  rd_sel_q;
  logic [31:0]           arr_rdata;
  logic                  unused_instr;

  assign unused_instr = mem_instr;

  // Wrap-around subtraction: addresses below BASE_ADDR land far out of range.
  assign offset   = addr_q - BASE_ADDR;
  assign in_range = {2'b00, offset[31:2]} < DEPTH_L;
  assign rom_hit  = ROM_GUARD && (wstrb_q != 4'b0000) && (offset < ROM_LIMIT);
  assign reject   = !in_range || rom_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    access     = 1'b0;
    case (state)
      IDLE: if (mem_valid) next_state = WAIT;
      WAIT: begin
        if (cnt == '0) begin
          access     = 1'b1;
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      mem_ready <= 1'b0;
      bus_err   <= 1'b0;
      rd_sel_q  <= 1'b0;
    end else begin
      mem_ready <= access;
      bus_err   <= access && reject;
      rd_sel_q  <= access && !reject && (wstrb_q == 4'b0000);
      if (state == IDLE && mem_valid) begin
        addr_q  <= {mem_addr[31:2], 2'b00};
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
        cnt     <= WAIT_CNT_W'(WAIT_CYCLES);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // The array strobe is not gated by reset: a write issued on the reset edge stands.
  bus_ram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .en   (access && !reject),
    .we   (wstrb_q),
    .addr (offset[AW+1:2]),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );

  assign mem_rdata = rd_sel_q ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_bus_ram.sv
// tb/tb_bus_ram.sv - self-checking bench for bus_ram (two instances, model-based)
module tb_bus_ram;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        valid [2];
  logic        instr [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic        ready [2];
  logic [31:0] rdata [2];
  logic        err   [2];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  bus_ram #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .BASE_ADDR(32'h0), .ROM_BYTES(1024)) dut_a (
    .clk(clk), .reset(rst[0]), .mem_valid(valid[0]), .mem_instr(instr[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
    .mem_ready(ready[0]), .mem_rdata(rdata[0]), .bus_err(err[0]));

  bus_ram #(.DEPTH_WORDS(16), .WAIT_CYCLES(3), .BASE_ADDR(32'h0), .ROM_BYTES(0)) dut_b (
    .clk(clk), .reset(rst[1]), .mem_valid(valid[1]), .mem_instr(instr[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
    .mem_ready(ready[1]), .mem_rdata(rdata[1]), .bus_err(err[1]));

  // ---------------- behavioural model ----------------
`ifdef BUS_RAM_ROM_GUARD_EN
  localparam bit GUARD_M = 1'b1;
`else
  localparam bit GUARD_M = 1'b0;
`endif
  int W_M   [2] = '{1, 3};
  int DEP_M [2] = '{1024, 16};
  int ROM_M [2] = '{1024, 0};

  logic [31:0] mdl [longint];
  int          cyc = 0;
  bit          pend [2];
  int          resp_edge [2];
  int          next_free [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wd [2];
  logic [3:0]  p_ws [2];
  bit          e_rdy [2];
  bit          e_err [2];
  bit          e_known [2];
  logic [31:0] e_rd [2];

  function automatic longint mkey(int k, logic [31:0] idx);
    return (longint'(k) << 32) | longint'(idx);
  endfunction

  function automatic void apply(int k);
    logic [31:0] off;
    longint      kk;
    logic [31:0] w;
    bit          rom;
    off = {p_addr[k][31:2], 2'b00};
    rom = GUARD_M && (p_ws[k] != 4'b0) && (off < 32'(ROM_M[k]));
    e_err[k]   = ((off >> 2) >= 32'(DEP_M[k])) || rom;
    e_rd[k]    = 32'h0;
    e_known[k] = 1'b1;
    if (!e_err[k]) begin
      kk = mkey(k, off >> 2);
      if (p_ws[k] == 4'b0) begin
        if (mdl.exists(kk)) e_rd[k] = mdl[kk];
        else e_known[k] = 1'b0;
      end else if (mdl.exists(kk) || p_ws[k] == 4'hF) begin
        w = mdl.exists(kk) ? mdl[kk] : 32'h0;
        for (int i = 0; i < 4; i++)
          if (p_ws[k][i]) w[8*i +: 8] = p_wd[k][8*i +: 8];
        mdl[kk] = w;
      end
    end
  endfunction

  function automatic void model_edge(int k);
    e_rdy[k] = 1'b0; e_err[k] = 1'b0; e_rd[k] = 32'h0; e_known[k] = 1'b1;
    if (rst[k]) begin
      if (pend[k] && cyc == resp_edge[k]) apply(k);
      e_err[k] = 1'b0; e_rd[k] = 32'h0; e_known[k] = 1'b1;
      pend[k] = 1'b0;
      next_free[k] = cyc + 1;
    end else if (pend[k] && cyc == resp_edge[k]) begin
      apply(k);
      e_rdy[k] = 1'b1;
      pend[k] = 1'b0;
      next_free[k] = cyc + 2;
    end else if (!pend[k] && cyc >= next_free[k] && valid[k]) begin
      pend[k] = 1'b1;
      p_addr[k] = addr[k]; p_wd[k] = wdata[k]; p_ws[k] = wstrb[k];
      resp_edge[k] = cyc + W_M[k] + 1;
    end
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_edge(k);
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready%0d", k), 32'(ready[k]), 32'(e_rdy[k]));
      chk($sformatf("err%0d", k), 32'(err[k]), 32'(e_err[k]));
      if (e_known[k]) chk($sformatf("rdata%0d", k), rdata[k], e_rd[k]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic access(input int k, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, output logic [31:0] rd,
                        output logic er, output int lat);
    @(negedge clk);
    valid[k] = 1'b1; addr[k] = a; wdata[k] = wd; wstrb[k] = ws; instr[k] = 1'b0;
    lat = 0; rd = 32'h0; er = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #2;
      if (ready[k]) begin
        lat = c; rd = rdata[k]; er = err[k];
        break;
      end
    end
    chk("ready_seen", 32'(lat != 0), 32'd1);
    @(negedge clk);
    valid[k] = 1'b0; wstrb[k] = 4'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; valid[k] = 1'b0; instr[k] = 1'b0;
      addr[k] = 32'h0; wdata[k] = 32'h0; wstrb[k] = 4'b0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    repeat (10) @(negedge clk);

    access(0, 32'h100, 32'hDEADBEEF, 4'hF, rd, er, lat);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_err", 32'(er), 32'd0);
    access(0, 32'h100, 32'h0, 4'h0, rd, er, lat);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_data", rd, 32'hDEADBEEF);
    access(0, 32'h100, 32'h000000AA, 4'b0001, rd, er, lat);
    access(0, 32'h100, 32'h0, 4'h0, rd, er, lat);
    chk("byte_lane", rd, 32'hDEADBEAA);
    access(0, 32'h103, 32'h0, 4'h0, rd, er, lat);
    chk("unaligned_rd", rd, 32'hDEADBEAA);
    access(0, 32'h104, 32'h0, 4'hF, rd, er, lat);
    access(0, 32'h104, 32'h11223344, 4'b1010, rd, er, lat);
    access(0, 32'h104, 32'h0, 4'h0, rd, er, lat);
    chk("lanes_1010", rd, 32'h11003300);
    access(0, 32'hFFC, 32'hCAFEF00D, 4'hF, rd, er, lat);
    access(0, 32'hFFC, 32'h0, 4'h0, rd, er, lat);
    chk("last_word", rd, 32'hCAFEF00D);
    chk("last_word_err", 32'(er), 32'd0);
    access(0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
    chk("a_oor_err", 32'(er), 32'd1);
    chk("a_oor_data", rd, 32'h0);
`ifdef BUS_RAM_ROM_GUARD_EN
    access(0, 32'h3FC, 32'hBADC0DE5, 4'hF, rd, er, lat);
    chk("rom_wr_err", 32'(er), 32'd1);
    access(0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
    chk("rom_rd_err", 32'(er), 32'd0);
    chk("rom_unchanged", 32'(rd != 32'hBADC0DE5), 32'd1);
    access(0, 32'h400, 32'h600DF00D, 4'hF, rd, er, lat);
    chk("rom_edge_wr_err", 32'(er), 32'd0);
    access(0, 32'h400, 32'h0, 4'h0, rd, er, lat);
    chk("rom_edge_rd", rd, 32'h600DF00D);
`endif

    for (int i = 0; i < 16; i++) begin
      access(1, 32'(4 * i), 32'hC0DE0000 | 32'(i * 17), 4'hF, rd, er, lat);
      if (i == 0) chk("b_wr_lat", 32'(lat), 32'd5);
    end
    access(1, 32'h40, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    chk("b_oor_wr_err", 32'(er), 32'd1);
    access(1, 32'h40, 32'h0, 4'h0, rd, er, lat);
    chk("b_oor_rd_err", 32'(er), 32'd1);
    chk("b_oor_rd_data", rd, 32'h0);
    access(1, 32'hFFFFFFFC, 32'h0, 4'h0, rd, er, lat);
    chk("b_wrap_err", 32'(er), 32'd1);
    for (int i = 0; i < 16; i++) begin
      access(1, 32'(4 * i), 32'h0, 4'h0, rd, er, lat);
      chk($sformatf("b_word%0d", i), rd, 32'hC0DE0000 | 32'(i * 17));
    end

    @(negedge clk);
    valid[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h12345678; wstrb[1] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst[1] = 1'b1; valid[1] = 1'b0; wstrb[1] = 4'b0;
    @(negedge clk);
    rst[1] = 1'b0;
    repeat (8) @(negedge clk);
    access(1, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("reset_abandon", rd, 32'hC0DE0088);
    chk("b_rd_lat", 32'(lat), 32'd5);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
